lms_sample_source: RTL and testbench

- Producer side of the LMS filter sample interface.
- Reads paired reference samples (input x[n], desired d[n]) from an external synchronous ROM and presents each pair to the LMS core on a valid/ready handshake.
- Paces sample issue with a programmable minimum gap, counts accepted samples, and flags completion.
- Sits inside top_lms_system, between the sample ROM and the LMS core, replacing free-running sample indexing.

---
 rtl/lms_pkg.sv | 16 +
 rtl/lms_sample_source.sv | 108 ++++++++++
 tb/tb_lms_sample_source.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lms_pkg.sv
// Constants and state type shared by the LMS sample path (top_lms_system, sample ROM, source).
package lms_pkg;

    localparam int unsigned LMS_DATA_W = 16;
    localparam int unsigned LMS_DEPTH  = 1024;
    localparam int unsigned LMS_ADDR_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StPresent,
        StGap,
        StDone
    } src_state_e;

endpackage

// File: rtl/lms_sample_source.sv
// Reads x/d sample pairs from a synchronous ROM and presents them to the LMS core over
// valid/ready, with optional inter-sample gap, looping and a done flag.
module lms_sample_source
    import lms_pkg::*;
#(
    parameter int unsigned DATA_W     = LMS_DATA_W,
    parameter int unsigned DEPTH      = LMS_DEPTH,
    parameter int unsigned ADDR_W     = LMS_ADDR_W,
    parameter int unsigned GAP_CYCLES = 0,
    parameter bit          LOOP       = 1'b0
) (
    input  logic              clk,
    input  logic              rst_btn,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_x,
    input  logic [DATA_W-1:0] rom_d,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] d_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [ADDR_W-1:0] sample_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    src_state_e        state;
    logic [ADDR_W-1:0] idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic              fetch_cnt;  // 0: ROM latching address, 1: ROM data settled

    assign rom_addr   = idx;
    assign sample_idx = idx;

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            state     <= StIdle;
            idx       <= '0;
            gap_cnt   <= '0;
            fetch_cnt <= 1'b0;
            x_out     <= '0;
            d_out     <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (stop) begin
            // A handshake coinciding with stop still delivers; counters are discarded.
            state     <= StIdle;
            idx       <= '0;
            gap_cnt   <= '0;
            fetch_cnt <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state     <= StFetch;
                        idx       <= '0;
                        fetch_cnt <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                StFetch: begin
                    if (!fetch_cnt) begin
                        fetch_cnt <= 1'b1;
                    end else begin
                        fetch_cnt <= 1'b0;
                        x_out     <= rom_x;
                        d_out     <= rom_d;
                        valid_out <= 1'b1;
                        state     <= StPresent;
                    end
                end
                StPresent: begin
                    if (valid_out && ready_in) begin
                        valid_out <= 1'b0;
                        if (idx == LAST_IDX && !LOOP) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
                            state <= (GAP_CYCLES > 0) ? StGap : StFetch;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= StFetch;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_sample_source.sv
// Bench for lms_sample_source: three instances (plain, gapped, looping) fed by ROM models.
module tb_lms_sample_source;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst_btn, start, stop, ready;
    logic [AW-1:0] addr_o[3];
    logic [AW-1:0] idx_o[3];
    logic [DW-1:0] rx[3];
    logic [DW-1:0] rd[3];
    logic [DW-1:0] x_o[3];
    logic [DW-1:0] d_o[3];
    logic          v_o[3];
    logic          busy_o[3];
    logic          done_o[3];
    logic [DW-1:0] mem_x[3][DP];
    logic [DW-1:0] mem_d[3][DP];
    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            rx[k] <= mem_x[k][addr_o[k]];
            rd[k] <= mem_d[k][addr_o[k]];
        end
    end

    lms_sample_source #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .GAP_CYCLES(0), .LOOP(1'b0)) u_basic (
        .clk(clk), .rst_btn(rst_btn), .start(start), .stop(stop), .rom_addr(addr_o[0]),
        .rom_x(rx[0]), .rom_d(rd[0]), .x_out(x_o[0]), .d_out(d_o[0]), .valid_out(v_o[0]),
        .ready_in(ready), .sample_idx(idx_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );
    lms_sample_source #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .GAP_CYCLES(4), .LOOP(1'b0)) u_gap (
        .clk(clk), .rst_btn(rst_btn), .start(start), .stop(stop), .rom_addr(addr_o[1]),
        .rom_x(rx[1]), .rom_d(rd[1]), .x_out(x_o[1]), .d_out(d_o[1]), .valid_out(v_o[1]),
        .ready_in(ready), .sample_idx(idx_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );
    lms_sample_source #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .GAP_CYCLES(0), .LOOP(1'b1)) u_loop (
        .clk(clk), .rst_btn(rst_btn), .start(start), .stop(stop), .rom_addr(addr_o[2]),
        .rom_x(rx[2]), .rom_d(rd[2]), .x_out(x_o[2]), .d_out(d_o[2]), .valid_out(v_o[2]),
        .ready_in(ready), .sample_idx(idx_o[2]), .busy(busy_o[2]), .done(done_o[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DP; i++) begin
                mem_x[k][i] = 16'(i + 1);
                mem_d[k][i] = 16'(-(i + 1));
            end
        end
    endtask

    task automatic do_reset();
        rst_btn = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        ready   = 1'b0;
        tick();
        tick();
        rst_btn = 1'b0;
        tick();
    endtask

    task automatic pulse_start(output int k);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc;
    endtask

    task automatic test_reset();
        fill_ramp();
        rst_btn = 1'b1;
        start   = 1'b1;
        stop    = 1'b0;
        ready   = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({v_o[k], busy_o[k], done_o[k]} !== 3'b000) begin
                bad++; $display("FAIL reset_flags[%0d]: got %b want 000", k, {v_o[k], busy_o[k], done_o[k]});
            end
            total++;
            if (idx_o[k] !== 3'd0 || addr_o[k] !== 3'd0) begin
                bad++; $display("FAIL reset_idx[%0d]: got %0d/%0d want 0/0", k, idx_o[k], addr_o[k]);
            end
            total++;
            if (x_o[k] !== 16'd0 || d_o[k] !== 16'd0) begin
                bad++; $display("FAIL reset_data[%0d]: got %h/%h want 0/0", k, x_o[k], d_o[k]);
            end
        end
        rst_btn = 1'b0;
        stop    = 1'b1;
        tick();
        tick();
        total++;
        if (busy_o[0] !== 1'b0 || v_o[0] !== 1'b0) begin
            bad++; $display("FAIL start_stop_idle: got busy=%b valid=%b want 0 0", busy_o[0], v_o[0]);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_basic();
        int k, hs, last_hs, first_v;
        fill_ramp();
        do_reset();
        ready = 1'b1;
        repeat (10) tick();
        pulse_start(k);
        total++;
        if (busy_o[0] !== 1'b1 || idx_o[0] !== 3'd0) begin
            bad++; $display("FAIL basic_busy: got busy=%b idx=%0d want 1 0", busy_o[0], idx_o[0]);
        end
        hs = 0; last_hs = -1; first_v = -1;
        for (int c = 0; c < 60 && hs < DP; c++) begin
            tick();
            if (v_o[0] && first_v < 0) first_v = cyc - k;
            if (v_o[0] && ready) begin
                total++;
                if (x_o[0] !== mem_x[0][hs] || d_o[0] !== mem_d[0][hs]) begin
                    bad++; $display("FAIL basic_data[%0d]: got %h/%h want %h/%h", hs, x_o[0], d_o[0],
                                    mem_x[0][hs], mem_d[0][hs]);
                end
                if (last_hs >= 0) begin
                    total++;
                    if (cyc + 1 - last_hs !== 3) begin
                        bad++; $display("FAIL basic_spacing: got %0d want 3", cyc + 1 - last_hs);
                    end
                end
                last_hs = cyc + 1;
                hs++;
            end
        end
        total++;
        if (first_v !== 2) begin
            bad++; $display("FAIL basic_latency: got %0d want 2", first_v);
        end
        total++;
        if (hs !== DP) begin
            bad++; $display("FAIL basic_count: got %0d want %0d", hs, DP);
        end
        tick();
        total++;
        if (done_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || v_o[0] !== 1'b0 || idx_o[0] !== 3'd7) begin
            bad++; $display("FAIL basic_done: got done=%b busy=%b valid=%b idx=%0d want 1 0 0 7",
                            done_o[0], busy_o[0], v_o[0], idx_o[0]);
        end
    endtask

    task automatic test_backpressure();
        int k;
        bit found;
        fill_ramp();
        do_reset();
        ready = 1'b1;
        pulse_start(k);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (v_o[0] && idx_o[0] == 3'd3) found = 1'b1;
        end
        ready = 1'b0;
        total++;
        if (!found) begin
            bad++; $display("FAIL bp_reach: got not found want sample 3 presented");
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (v_o[0] !== 1'b1 || x_o[0] !== 16'd4 || d_o[0] !== 16'hfffc || idx_o[0] !== 3'd3) begin
                bad++; $display("FAIL bp_hold: got v=%b x=%h d=%h idx=%0d want 1 0004 fffc 3",
                                v_o[0], x_o[0], d_o[0], idx_o[0]);
            end
        end
        ready = 1'b1;
        tick();
        total++;
        if (idx_o[0] !== 3'd4 || v_o[0] !== 1'b0) begin
            bad++; $display("FAIL bp_release: got idx=%0d v=%b want 4 0", idx_o[0], v_o[0]);
        end
    endtask

    task automatic test_gap();
        int k, hs, last_hs, low_run;
        fill_ramp();
        do_reset();
        ready = 1'b1;
        pulse_start(k);
        hs = 0; last_hs = -1; low_run = 0;
        for (int c = 0; c < 120 && hs < DP; c++) begin
            tick();
            if (!v_o[1] && last_hs >= 0) low_run++;
            if (v_o[1] && low_run > 0) begin
                total++;
                if (low_run !== 6) begin
                    bad++; $display("FAIL gap_low_run: got %0d want 6", low_run);
                end
                low_run = 0;
            end
            if (v_o[1] && ready) begin
                total++;
                if (x_o[1] !== mem_x[1][hs] || d_o[1] !== mem_d[1][hs]) begin
                    bad++; $display("FAIL gap_data[%0d]: got %h/%h want %h/%h", hs, x_o[1], d_o[1],
                                    mem_x[1][hs], mem_d[1][hs]);
                end
                if (last_hs >= 0) begin
                    total++;
                    if (cyc + 1 - last_hs !== 7) begin
                        bad++; $display("FAIL gap_spacing: got %0d want 7", cyc + 1 - last_hs);
                    end
                end
                last_hs = cyc + 1;
                hs++;
            end
        end
        tick();
        total++;
        if (hs !== DP || done_o[1] !== 1'b1) begin
            bad++; $display("FAIL gap_done: got hs=%0d done=%b want %0d 1", hs, done_o[1], DP);
        end
    endtask

    task automatic test_wrap();
        int k, hs;
        bit any_done;
        fill_ramp();
        do_reset();
        ready = 1'b1;
        pulse_start(k);
        hs = 0; any_done = 1'b0;
        for (int c = 0; c < 80 && hs < 12; c++) begin
            tick();
            any_done |= done_o[2];
            if (v_o[2] && ready) begin
                total++;
                if (x_o[2] !== mem_x[2][hs % DP] || idx_o[2] !== 3'(hs % DP)) begin
                    bad++; $display("FAIL wrap_data[%0d]: got x=%h idx=%0d want %h %0d", hs, x_o[2],
                                    idx_o[2], mem_x[2][hs % DP], hs % DP);
                end
                hs++;
            end
        end
        total++;
        if (hs !== 12 || any_done !== 1'b0) begin
            bad++; $display("FAIL wrap_run: got hs=%0d done_seen=%b want 12 0", hs, any_done);
        end
    endtask

    task automatic test_abort();
        int k, first_v;
        bit found;
        fill_ramp();
        do_reset();
        ready = 1'b1;
        pulse_start(k);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (v_o[0] && idx_o[0] == 3'd5) found = 1'b1;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if (!found || v_o[0] !== 1'b0 || idx_o[0] !== 3'd0 || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
            bad++; $display("FAIL abort_idle: got found=%b v=%b idx=%0d busy=%b done=%b want 1 0 0 0 0",
                            found, v_o[0], idx_o[0], busy_o[0], done_o[0]);
        end
        pulse_start(k);
        first_v = -1;
        for (int c = 0; c < 10 && first_v < 0; c++) begin
            tick();
            if (v_o[0]) first_v = cyc - k;
        end
        total++;
        if (first_v !== 2 || x_o[0] !== 16'd1 || idx_o[0] !== 3'd0) begin
            bad++; $display("FAIL abort_restart: got lat=%0d x=%h idx=%0d want 2 0001 0",
                            first_v, x_o[0], idx_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        int k, first_v;
        bit found;
        fill_ramp();
        do_reset();
        ready = 1'b1;
        pulse_start(k);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (busy_o[0] && !v_o[0] && idx_o[0] == 3'd2) found = 1'b1;
        end
        #2 rst_btn = 1'b1;
        #1;
        total++;
        if (!found || {v_o[0], busy_o[0], done_o[0]} !== 3'b000 || idx_o[0] !== 3'd0 ||
            addr_o[0] !== 3'd0 || x_o[0] !== 16'd0 || d_o[0] !== 16'd0) begin
            bad++; $display("FAIL rst_async: got found=%b v=%b busy=%b idx=%0d x=%h want 1 0 0 0 0000",
                            found, v_o[0], busy_o[0], idx_o[0], x_o[0]);
        end
        start = 1'b1;
        tick();
        total++;
        if (busy_o[0] !== 1'b0 || v_o[0] !== 1'b0) begin
            bad++; $display("FAIL rst_start_ignored: got busy=%b v=%b want 0 0", busy_o[0], v_o[0]);
        end
        start   = 1'b0;
        rst_btn = 1'b0;
        tick();
        pulse_start(k);
        first_v = -1;
        for (int c = 0; c < 10 && first_v < 0; c++) begin
            tick();
            if (v_o[0]) first_v = cyc - k;
        end
        total++;
        if (first_v !== 2 || x_o[0] !== 16'd1 || idx_o[0] !== 3'd0) begin
            bad++; $display("FAIL rst_restart: got lat=%0d x=%h idx=%0d want 2 0001 0",
                            first_v, x_o[0], idx_o[0]);
        end
    endtask

    task automatic test_random();
        int k, hs;
        bit held;
        logic [DW-1:0] hx, hd;
        for (int i = 0; i < DP; i++) begin
            mem_x[0][i] = 16'($urandom);
            mem_d[0][i] = 16'($urandom);
        end
        do_reset();
        ready = 1'($urandom_range(0, 1));
        pulse_start(k);
        hs = 0; held = 1'b0; hx = '0; hd = '0;
        for (int c = 0; c < 400 && hs < DP; c++) begin
            tick();
            if (held) begin
                total++;
                if (v_o[0] !== 1'b1 || x_o[0] !== hx || d_o[0] !== hd) begin
                    bad++; $display("FAIL rand_hold: got v=%b x=%h d=%h want 1 %h %h", v_o[0], x_o[0],
                                    d_o[0], hx, hd);
                end
            end
            hx = x_o[0];
            hd = d_o[0];
            ready = 1'($urandom_range(0, 1));
            if (v_o[0] && ready) begin
                total++;
                if (x_o[0] !== mem_x[0][hs] || d_o[0] !== mem_d[0][hs]) begin
                    bad++; $display("FAIL rand_data[%0d]: got %h/%h want %h/%h", hs, x_o[0], d_o[0],
                                    mem_x[0][hs], mem_d[0][hs]);
                end
                hs++;
                held = 1'b0;
            end else begin
                held = v_o[0];
            end
        end
        tick();
        total++;
        if (hs !== DP || done_o[0] !== 1'b1 || idx_o[0] !== 3'd7) begin
            bad++; $display("FAIL rand_done: got hs=%0d done=%b idx=%0d want %0d 1 7", hs, done_o[0],
                            idx_o[0], DP);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
